mastermind_board: RTL and testbench

Parametrised guess-board and scoring engine for the Mastermind/Wordle game, generalising the fixed 4-slot, 6-guess core. It holds the secret, edits the current guess row under cursor control, and scores a submitted row sequentially into exact and colour-only peg counts. It also keeps a per-row feedback history. It sits between the debounced-button/switch logic and the VGA renderer, which consumes `board_flat` and `feedback_flat` directly.

---
 rtl/mastermind_board.sv | 275 +++++++++++++++++++++++++++
 tb/tb_mastermind_board.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mastermind_board.sv
// -----------------------------------------------------------------------------
// mastermind_board
//
// Guess board and scoring engine for a Mastermind-style game. It holds the
// secret, lets the player edit the current guess row under cursor control, and
// scores a submitted row over several cycles into exact and colour-only peg
// counts. It also keeps a feedback history with one entry per row.
//
// Ports
//   Clk, Reset_n        : clock (rising edge) and asynchronous active-low reset
//   start               : pulse; latches `secret` and starts a new game
//   secret              : slot k at [k*COLOR_W +: COLOR_W]
//   color               : colour code to write (0 clears the slot)
//   set_color           : pulse; write `color` at the cursor
//   move_left/right     : pulses; move the cursor (wrapping)
//   submit              : pulse; score the current row
//   cursor, guess_num   : cursor slot, rows already scored
//   board_flat          : row r, slot k at [(r*SLOTS+k)*COLOR_W +: COLOR_W]
//   feedback_flat       : row r exact at [r*2*FW +: FW], colour at +FW
//   exact_cnt/color_cnt : counts of the most recently scored row
//   fb_valid            : high during the cycle a new score is committed
//   reject              : one-cycle pulse after an illegal request
//   q_*                 : one-hot state flags
// -----------------------------------------------------------------------------
module mastermind_board #(
  parameter  int SLOTS       = 4,
  parameter  int COLOR_W     = 3,
  parameter  int NCOLORS     = 6,
  parameter  int MAX_GUESSES = 6,
  localparam int CW          = $clog2(SLOTS),
  localparam int FW          = $clog2(SLOTS + 1),
  localparam int GW          = $clog2(MAX_GUESSES + 1)
) (
  input  logic                                  Clk,
  input  logic                                  Reset_n,
  input  logic                                  start,
  input  logic [SLOTS*COLOR_W-1:0]              secret,
  input  logic [COLOR_W-1:0]                    color,
  input  logic                                  set_color,
  input  logic                                  move_left,
  input  logic                                  move_right,
  input  logic                                  submit,
  output logic [CW-1:0]                         cursor,
  output logic [GW-1:0]                         guess_num,
  output logic [MAX_GUESSES*SLOTS*COLOR_W-1:0]  board_flat,
  output logic [MAX_GUESSES*2*FW-1:0]           feedback_flat,
  output logic [FW-1:0]                         exact_cnt,
  output logic [FW-1:0]                         color_cnt,
  output logic                                  fb_valid,
  output logic                                  reject,
  output logic                                  q_Start,
  output logic                                  q_Input,
  output logic                                  q_Score,
  output logic                                  q_DoneC,
  output logic                                  q_DoneNC
);

  // Row index width; guess_num needs one extra code for "all rows used".
  localparam int RW = (MAX_GUESSES > 1) ? $clog2(MAX_GUESSES) : 1;
  localparam int NHIST = 2 ** COLOR_W;

  localparam logic [CW-1:0]      LAST_SLOT = CW'(SLOTS - 1);
  localparam logic [COLOR_W-1:0] MAX_COLOR = COLOR_W'(NCOLORS);
  localparam logic [FW-1:0]      ALL_EXACT = FW'(SLOTS);
  localparam logic [GW-1:0]      LAST_ROWS = GW'(MAX_GUESSES);

  typedef enum logic [2:0] {
    S_START,
    S_INPUT,
    S_SCORE_EXACT,
    S_SCORE_COLOR,
    S_FEEDBACK,
    S_DONE_C,
    S_DONE_NC
  } state_t;

  typedef logic [SLOTS-1:0][COLOR_W-1:0] row_t;

  state_t                                state_q, state_d;
  row_t                                  secret_q, secret_d;
  logic [MAX_GUESSES-1:0][SLOTS-1:0][COLOR_W-1:0] board_q, board_d;
  logic [MAX_GUESSES-1:0][1:0][FW-1:0]   feedback_q, feedback_d;
  // Histograms of the non-exact secret and guess colours, indexed by colour.
  logic [NHIST-1:0][FW-1:0]              hist_s_q, hist_s_d;
  logic [NHIST-1:0][FW-1:0]              hist_g_q, hist_g_d;
  logic [CW-1:0]                         cursor_q, cursor_d;
  logic [GW-1:0]                         guess_num_q, guess_num_d;
  logic [CW-1:0]                         slot_idx_q, slot_idx_d;
  logic [COLOR_W-1:0]                    col_idx_q, col_idx_d;
  logic [FW-1:0]                         exact_acc_q, exact_acc_d;
  logic [FW-1:0]                         color_acc_q, color_acc_d;
  logic [FW-1:0]                         exact_cnt_q, exact_cnt_d;
  logic [FW-1:0]                         color_cnt_q, color_cnt_d;
  logic                                  reject_q, reject_d;

  logic [RW-1:0] row;
  assign row = guess_num_q[RW-1:0];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    logic               row_full;
    logic [COLOR_W-1:0] g_val;
    logic [COLOR_W-1:0] s_val;
    logic [FW-1:0]      h_min;

    // NOTE: every variable gets a default before the case statement, so no
    // path can leave one unassigned and synthesis cannot infer a latch.
    state_d     = state_q;
    secret_d    = secret_q;
    board_d     = board_q;
    feedback_d  = feedback_q;
    hist_s_d    = hist_s_q;
    hist_g_d    = hist_g_q;
    cursor_d    = cursor_q;
    guess_num_d = guess_num_q;
    slot_idx_d  = slot_idx_q;
    col_idx_d   = col_idx_q;
    exact_acc_d = exact_acc_q;
    color_acc_d = color_acc_q;
    exact_cnt_d = exact_cnt_q;
    color_cnt_d = color_cnt_q;
    reject_d    = 1'b0;
    row_full    = 1'b1;
    g_val       = board_q[row][slot_idx_q];
    s_val       = secret_q[slot_idx_q];
    h_min       = (hist_s_q[col_idx_q] < hist_g_q[col_idx_q]) ?
                  hist_s_q[col_idx_q] : hist_g_q[col_idx_q];

    for (int k = 0; k < SLOTS; k++) begin
      if (board_q[row][k] == '0) row_full = 1'b0;
    end

    case (state_q)
      S_START, S_DONE_C, S_DONE_NC: begin
        if (start) begin
          board_d     = '0;
          feedback_d  = '0;
          exact_cnt_d = '0;
          color_cnt_d = '0;
          cursor_d    = '0;
          guess_num_d = '0;
          secret_d    = secret;
          state_d     = S_INPUT;
        end
      end

      S_INPUT: begin
        if (submit) begin
          // A same-cycle edit is dropped whether or not the submit is legal.
          if (!row_full) begin
            reject_d = 1'b1;
          end else begin
            hist_s_d    = '0;
            hist_g_d    = '0;
            exact_acc_d = '0;
            color_acc_d = '0;
            slot_idx_d  = '0;
            state_d     = S_SCORE_EXACT;
          end
        end else begin
          if (set_color) begin
            if (color > MAX_COLOR) reject_d = 1'b1;
            else                   board_d[row][cursor_q] = color;
          end
          // The write above uses the old cursor; the move lands afterwards.
          if (move_right && !move_left) begin
            cursor_d = (cursor_q == LAST_SLOT) ? '0 : cursor_q + 1'b1;
          end else if (move_left && !move_right) begin
            cursor_d = (cursor_q == '0) ? LAST_SLOT : cursor_q - 1'b1;
          end
        end
      end

      S_SCORE_EXACT: begin
        if (g_val == s_val) begin
          exact_acc_d = exact_acc_q + 1'b1;
        end else begin
          hist_s_d[s_val] = hist_s_q[s_val] + 1'b1;
          hist_g_d[g_val] = hist_g_q[g_val] + 1'b1;
        end
        if (slot_idx_q == LAST_SLOT) begin
          col_idx_d = COLOR_W'(1);
          state_d   = S_SCORE_COLOR;
        end else begin
          slot_idx_d = slot_idx_q + 1'b1;
        end
      end

      S_SCORE_COLOR: begin
        color_acc_d = color_acc_q + h_min;
        if (col_idx_q == MAX_COLOR) state_d   = S_FEEDBACK;
        else                        col_idx_d = col_idx_q + 1'b1;
      end

      S_FEEDBACK: begin
        feedback_d[row][0] = exact_acc_q;
        feedback_d[row][1] = color_acc_q;
        exact_cnt_d        = exact_acc_q;
        color_cnt_d        = color_acc_q;
        guess_num_d        = guess_num_q + 1'b1;
        cursor_d           = '0;
        if (exact_acc_q == ALL_EXACT)      state_d = S_DONE_C;
        else if (guess_num_d == LAST_ROWS) state_d = S_DONE_NC;
        else                               state_d = S_INPUT;
      end

      default: state_d = S_START;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: the board, feedback and histogram arrays are reset along with the
  // control flops, because the renderer reads them straight after reset and
  // must see an empty board.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_START;
      secret_q    <= '0;
      board_q     <= '0;
      feedback_q  <= '0;
      hist_s_q    <= '0;
      hist_g_q    <= '0;
      cursor_q    <= '0;
      guess_num_q <= '0;
      slot_idx_q  <= '0;
      col_idx_q   <= '0;
      exact_acc_q <= '0;
      color_acc_q <= '0;
      exact_cnt_q <= '0;
      color_cnt_q <= '0;
      reject_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q     <= state_d;
      secret_q    <= secret_d;
      board_q     <= board_d;
      feedback_q  <= feedback_d;
      hist_s_q    <= hist_s_d;
      hist_g_q    <= hist_g_d;
      cursor_q    <= cursor_d;
      guess_num_q <= guess_num_d;
      slot_idx_q  <= slot_idx_d;
      col_idx_q   <= col_idx_d;
      exact_acc_q <= exact_acc_d;
      color_acc_q <= color_acc_d;
      exact_cnt_q <= exact_cnt_d;
      color_cnt_q <= color_cnt_d;
      reject_q    <= reject_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cursor        = cursor_q;
  assign guess_num     = guess_num_q;
  assign board_flat    = board_q;
  assign feedback_flat = feedback_q;
  assign exact_cnt     = exact_cnt_q;
  assign color_cnt     = color_cnt_q;
  assign reject        = reject_q;
  assign fb_valid      = (state_q == S_FEEDBACK);
  assign q_Start       = (state_q == S_START);
  assign q_Input       = (state_q == S_INPUT);
  assign q_Score       = (state_q == S_SCORE_EXACT) || (state_q == S_SCORE_COLOR) ||
                         (state_q == S_FEEDBACK);
  assign q_DoneC       = (state_q == S_DONE_C);
  assign q_DoneNC      = (state_q == S_DONE_NC);

endmodule

// File: tb/tb_mastermind_board.sv
// -----------------------------------------------------------------------------
// tb_mastermind_board
//
// Bench for mastermind_board. A default-parameter instance is driven through
// directed and randomised games against a reference model that scores rows
// from colour counts (total colour matches minus exact matches). A second
// instance with SLOTS=5, NCOLORS=7, MAX_GUESSES=8 checks the longer latency.
// -----------------------------------------------------------------------------
module tb_mastermind_board;

  localparam int S   = 4;
  localparam int CWD = 3;
  localparam int N   = 6;
  localparam int MG  = 6;
  localparam int CW  = $clog2(S);
  localparam int FW  = $clog2(S + 1);
  localparam int GW  = $clog2(MG + 1);

  localparam int S2  = 5;
  localparam int N2  = 7;
  localparam int MG2 = 8;
  localparam int CW2 = $clog2(S2);
  localparam int FW2 = $clog2(S2 + 1);
  localparam int GW2 = $clog2(MG2 + 1);

  localparam logic [4:0] F_START  = 5'b10000;
  localparam logic [4:0] F_INPUT  = 5'b01000;
  localparam logic [4:0] F_SCORE  = 5'b00100;
  localparam logic [4:0] F_DONEC  = 5'b00010;
  localparam logic [4:0] F_DONENC = 5'b00001;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0, set_color = 1'b0, move_left = 1'b0;
  logic                  move_right = 1'b0, submit = 1'b0;
  logic [S*CWD-1:0]      secret = '0;
  logic [CWD-1:0]        color = '0;
  logic [CW-1:0]         cursor;
  logic [GW-1:0]         guess_num;
  logic [MG*S*CWD-1:0]   board_flat;
  logic [MG*2*FW-1:0]    feedback_flat;
  logic [FW-1:0]         exact_cnt, color_cnt;
  logic                  fb_valid, reject;
  logic                  q_Start, q_Input, q_Score, q_DoneC, q_DoneNC;
  logic [4:0]            flags;

  logic                  b_start = 1'b0, b_set_color = 1'b0, b_move_right = 1'b0;
  logic                  b_submit = 1'b0;
  logic [S2*CWD-1:0]     b_secret = '0;
  logic [CWD-1:0]        b_color = '0;
  logic [CW2-1:0]        b_cursor;
  logic [GW2-1:0]        b_guess_num;
  logic [MG2*S2*CWD-1:0] b_board_flat;
  logic [MG2*2*FW2-1:0]  b_feedback_flat;
  logic [FW2-1:0]        b_exact_cnt, b_color_cnt;
  logic                  b_fb_valid, b_reject;
  logic                  b_q_Start, b_q_Input, b_q_Score, b_q_DoneC, b_q_DoneNC;

  assign flags = {q_Start, q_Input, q_Score, q_DoneC, q_DoneNC};

  always #5 clk = ~clk;

  mastermind_board #(.SLOTS(S), .COLOR_W(CWD), .NCOLORS(N), .MAX_GUESSES(MG)) dut (
    .Clk(clk), .Reset_n(rst_n), .start(start), .secret(secret), .color(color),
    .set_color(set_color), .move_left(move_left), .move_right(move_right),
    .submit(submit), .cursor(cursor), .guess_num(guess_num),
    .board_flat(board_flat), .feedback_flat(feedback_flat),
    .exact_cnt(exact_cnt), .color_cnt(color_cnt), .fb_valid(fb_valid),
    .reject(reject), .q_Start(q_Start), .q_Input(q_Input), .q_Score(q_Score),
    .q_DoneC(q_DoneC), .q_DoneNC(q_DoneNC)
  );

  mastermind_board #(.SLOTS(S2), .COLOR_W(CWD), .NCOLORS(N2), .MAX_GUESSES(MG2)) dut_b (
    .Clk(clk), .Reset_n(rst_n), .start(b_start), .secret(b_secret), .color(b_color),
    .set_color(b_set_color), .move_left(1'b0), .move_right(b_move_right),
    .submit(b_submit), .cursor(b_cursor), .guess_num(b_guess_num),
    .board_flat(b_board_flat), .feedback_flat(b_feedback_flat),
    .exact_cnt(b_exact_cnt), .color_cnt(b_color_cnt), .fb_valid(b_fb_valid),
    .reject(b_reject), .q_Start(b_q_Start), .q_Input(b_q_Input), .q_Score(b_q_Score),
    .q_DoneC(b_q_DoneC), .q_DoneNC(b_q_DoneNC)
  );

  int checks = 0;
  int errors = 0;

  // Reference model of the default instance.
  int         m_secret[S];
  int         m_board[MG][S];
  int         m_fb_ex[MG];
  int         m_fb_co[MG];
  int         m_cur, m_gnum, m_ex, m_co;
  logic [4:0] m_flags;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MG*S*CWD-1:0] exp_board();
    logic [MG*S*CWD-1:0] v = '0;
    for (int r = 0; r < MG; r++)
      for (int k = 0; k < S; k++) v[(r*S+k)*CWD +: CWD] = CWD'(m_board[r][k]);
    return v;
  endfunction

  function automatic logic [MG*2*FW-1:0] exp_fb();
    logic [MG*2*FW-1:0] v = '0;
    for (int r = 0; r < MG; r++) begin
      v[r*2*FW +: FW]      = FW'(m_fb_ex[r]);
      v[r*2*FW + FW +: FW] = FW'(m_fb_co[r]);
    end
    return v;
  endfunction

  // Colour pegs = sum over colours of min(count in secret, count in guess),
  // minus the exact hits.
  function automatic void score_model(input int sec[$], input int g[$], input int n,
                                      output int ex, output int co);
    int tot = 0;
    ex = 0;
    foreach (sec[i]) if (sec[i] == g[i]) ex++;
    for (int c = 1; c <= n; c++) begin
      int cs = 0;
      int cg = 0;
      foreach (sec[i]) begin
        if (sec[i] == c) cs++;
        if (g[i] == c) cg++;
      end
      tot += (cs < cg) ? cs : cg;
    end
    co = tot - ex;
  endfunction

  task automatic model_clear();
    foreach (m_board[r, k]) m_board[r][k] = 0;
    foreach (m_fb_ex[r]) begin
      m_fb_ex[r] = 0;
      m_fb_co[r] = 0;
    end
    m_cur = 0; m_gnum = 0; m_ex = 0; m_co = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    start = 0; set_color = 0; move_left = 0; move_right = 0; submit = 0;
    b_start = 0; b_set_color = 0; b_move_right = 0; b_submit = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_flags"}, flags, m_flags);
    check({tag, "_board"}, board_flat, exp_board());
    check({tag, "_fb"}, feedback_flat, exp_fb());
    check({tag, "_cursor"}, cursor, m_cur);
    check({tag, "_gnum"}, guess_num, m_gnum);
    check({tag, "_exact"}, exact_cnt, m_ex);
    check({tag, "_color"}, color_cnt, m_co);
  endtask

  task automatic do_start(input int sec[S], input string tag);
    for (int k = 0; k < S; k++) secret[k*CWD +: CWD] = CWD'(sec[k]);
    start = 1;
    step();
    model_clear();
    m_secret = sec;
    m_flags  = F_INPUT;
    check_all(tag);
  endtask

  task automatic edit(input bit set, input int col, input bit ml, input bit mr,
                      input string tag);
    bit exp_rej = 0;
    set_color = set; color = CWD'(col); move_left = ml; move_right = mr;
    step();
    if (set) begin
      if (col > N) exp_rej = 1;
      else         m_board[m_gnum][m_cur] = col;
    end
    if (ml && !mr) m_cur = (m_cur + S - 1) % S;
    if (mr && !ml) m_cur = (m_cur + 1) % S;
    check({tag, "_rej"}, reject, exp_rej);
    check({tag, "_cursor"}, cursor, m_cur);
    check({tag, "_board"}, board_flat, exp_board());
  endtask

  task automatic fill_row(input int g[S], input string tag);
    for (int k = 0; k < S; k++) edit(1, g[k], 0, 1, tag);
  endtask

  task automatic do_submit(input string tag);
    bit full = 1;
    int lat;
    int sq[$];
    int gq[$];
    for (int k = 0; k < S; k++) if (m_board[m_gnum][k] == 0) full = 0;
    submit = 1;
    step();
    if (!full) begin
      check({tag, "_rej"}, reject, 1);
      check({tag, "_flags"}, flags, F_INPUT);
      check({tag, "_board"}, board_flat, exp_board());
      return;
    end
    lat = 1;
    check({tag, "_scoring"}, flags, F_SCORE);
    check({tag, "_norej"}, reject, 0);
    while (fb_valid !== 1'b1 && lat < 60) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, lat, S + N + 1);
    check({tag, "_fbvalid"}, fb_valid, 1);
    for (int k = 0; k < S; k++) begin
      sq.push_back(m_secret[k]);
      gq.push_back(m_board[m_gnum][k]);
    end
    score_model(sq, gq, N, m_ex, m_co);
    m_fb_ex[m_gnum] = m_ex;
    m_fb_co[m_gnum] = m_co;
    m_gnum++;
    m_cur = 0;
    if (m_ex == S)        m_flags = F_DONEC;
    else if (m_gnum == MG) m_flags = F_DONENC;
    else                  m_flags = F_INPUT;
    step();
    check({tag, "_fbdrop"}, fb_valid, 0);
    check_all(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sec[S];
    int g[S];
    int lat;

    // ---------------- reset values ----------------
    model_clear();
    m_flags = F_START;
    repeat (2) @(posedge clk);
    #1;
    check_all("in_reset");
    check("in_reset_fbvalid", fb_valid, 0);
    check("in_reset_reject", reject, 0);
    rst_n = 1;
    step();
    check_all("reset");
    check("reset_fbvalid", fb_valid, 0);
    check("reset_reject", reject, 0);

    // ---------------- game 1: editing, permutation, duplicates, win --------
    sec = '{1, 2, 3, 4};
    do_start(sec, "start1");
    edit(0, 0, 1, 0, "wrap_left");
    check("wrap_left_is3", cursor, 3);
    edit(0, 0, 1, 1, "both_moves");
    edit(0, 0, 0, 1, "wrap_right");
    edit(1, 7, 0, 0, "bad_color");
    edit(1, 4, 0, 1, "set_move");
    edit(1, 3, 0, 1, "set_move2");
    edit(0, 0, 0, 1, "skip_slot2");
    edit(1, 1, 0, 1, "set_slot3");
    do_submit("empty_slot");
    edit(0, 0, 1, 0, "back1");
    edit(0, 0, 1, 0, "back2");
    edit(1, 2, 0, 0, "fill_slot2");
    do_submit("perm");
    check("perm_exact_k", exact_cnt, 0);
    check("perm_color_k", color_cnt, 4);
    g = '{1, 1, 2, 2};
    fill_row(g, "dup_fill");
    do_submit("dup");
    check("dup_exact_k", exact_cnt, 1);
    check("dup_color_k", color_cnt, 1);
    g = '{1, 2, 3, 4};
    fill_row(g, "win_fill");
    do_submit("win");
    check("win_donec", q_DoneC, 1);
    submit = 1;
    step();
    check("done_submit_flags", flags, F_DONEC);
    check("done_submit_gnum", guess_num, 3);
    check("done_submit_rej", reject, 0);
    set_color = 1; color = 5;
    step();
    check("done_edit_board", board_flat, exp_board());

    // ---------------- game 2: random loss over all rows --------------------
    for (int k = 0; k < S; k++) sec[k] = $urandom_range(1, N);
    do_start(sec, "start2");
    check("start2_board_clear", board_flat, 0);
    for (int r = 0; r < MG; r++) begin
      bit same;
      for (int e = 0; e < 6; e++)
        edit($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
             $urandom_range(0, 1), "rand_edit");
      while (m_cur != 0) edit(0, 0, 0, 1, "align");
      do begin
        same = 1;
        for (int k = 0; k < S; k++) begin
          g[k] = $urandom_range(1, N);
          if (g[k] != sec[k]) same = 0;
        end
      end while (same);
      fill_row(g, "loss_fill");
      do_submit("loss_row");
    end
    check("loss_donenc", q_DoneNC, 1);
    check("loss_gnum", guess_num, MG);

    // ---------------- game 3: reset during colour scoring ------------------
    for (int k = 0; k < S; k++) sec[k] = $urandom_range(1, N);
    do_start(sec, "start3");
    g = '{1, 2, 3, 4};
    fill_row(g, "abort_fill");
    submit = 1;
    step();
    repeat (S + 1) step();
    check("abort_in_score", flags, F_SCORE);
    #2;
    rst_n = 0;
    #1;
    model_clear();
    m_flags = F_START;
    check_all("abort_async");
    check("abort_fbvalid_async", fb_valid, 0);
    step();
    check("abort_fbvalid_held", fb_valid, 0);
    rst_n = 1;
    for (int i = 0; i < N + 2; i++) begin
      step();
      check("abort_no_fbvalid", fb_valid, 0);
    end
    check_all("abort_after");

    // ---------------- second instance: 5 slots, 7 colours ------------------
    begin
      int b_sec[S2];
      int b_g[S2];
      int sq[$];
      int gq[$];
      int ex, co;
      for (int k = 0; k < S2; k++) begin
        b_sec[k] = $urandom_range(1, N2);
        b_secret[k*CWD +: CWD] = CWD'(b_sec[k]);
      end
      b_start = 1;
      step();
      check("b_start_input", b_q_Input, 1);
      for (int r = 0; r < 2; r++) begin
        sq.delete();
        gq.delete();
        for (int k = 0; k < S2; k++) begin
          b_g[k] = (r == 0) ? b_sec[S2-1-k] : $urandom_range(1, N2);
          b_color = CWD'(b_g[k]); b_set_color = 1; b_move_right = 1;
          step();
          sq.push_back(b_sec[k]);
          gq.push_back(b_g[k]);
        end
        b_submit = 1;
        step();
        lat = 1;
        while (b_fb_valid !== 1'b1 && lat < 60) begin
          step();
          lat++;
        end
        check("b_latency", lat, 13);
        step();
        score_model(sq, gq, N2, ex, co);
        check("b_exact", b_exact_cnt, ex);
        check("b_color", b_color_cnt, co);
        check("b_gnum", b_guess_num, (ex == S2) ? 1 : r + 1);
        check("b_cursor", b_cursor, 0);
        if (ex == S2) break;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
